// File: rtl/complex_dot_product_feeder_if.sv
// Job, row-memory and dot-product-unit signals of the complex dot-product feeder.
// master is the feeder's view; slave is the view of the surrounding system.
interface complex_dot_product_feeder_if #(
  parameter int element_width = 64,
  parameter int NI            = 8,
  parameter int ADDR_W        = 10
);
  logic                        start;
  logic [ADDR_W-1:0]           a_base;
  logic [ADDR_W-1:0]           b_base;
  logic                        busy;

  logic                        mem_a_rd;
  logic                        mem_b_rd;
  logic [ADDR_W-1:0]           mem_a_addr;
  logic [ADDR_W-1:0]           mem_b_addr;
  logic [element_width*NI-1:0] mem_a_rdata;
  logic [element_width*NI-1:0] mem_b_rdata;

  logic                        dp_reset;
  logic                        dp_read_now;
  logic [element_width*NI-1:0] dp_first_row;
  logic [element_width*NI-1:0] dp_second_row;
  logic                        dp_finish;
  logic [element_width-1:0]    dp_result;

  logic [element_width-1:0]    result;
  logic                        result_valid;
  logic                        result_error;
  logic                        result_ready;

  modport master (
    input  start, a_base, b_base, mem_a_rdata, mem_b_rdata, dp_finish, dp_result, result_ready,
    output busy, mem_a_rd, mem_b_rd, mem_a_addr, mem_b_addr, dp_reset, dp_read_now,
           dp_first_row, dp_second_row, result, result_valid, result_error
  );

  modport slave (
    output start, a_base, b_base, mem_a_rdata, mem_b_rdata, dp_finish, dp_result, result_ready,
    input  busy, mem_a_rd, mem_b_rd, mem_a_addr, mem_b_addr, dp_reset, dp_read_now,
           dp_first_row, dp_second_row, result, result_valid, result_error
  );
endinterface

// File: rtl/complex_dot_product_feeder.sv
// Streams two rows of complex packages from memory into a dot-product unit, two cycles
// per package, then waits (bounded) for the unit's result and hands it to the consumer.
//
//   state    | meaning
//   IDLE     | waiting for start
//   CLR      | dp_reset pulse
//   FETCH    | reads for package 0 in flight
//   LOAD     | package 0 captured into the row registers
//   DRIVE0   | first cycle of package k (dp_read_now on k=0, prefetch k+1)
//   DRIVE1   | second cycle of package k (load k+1 or finish streaming)
//   WAIT_FIN | waiting for dp_finish, timeout down-counter running
//   RESULT   | result held until result_ready
module complex_dot_product_feeder #(
  parameter int element_width = 64,
  parameter int NI            = 8,
  parameter int NOE           = 8,
  parameter int ADDR_W        = 10,
  parameter int TIMEOUT       = 255
) (
  input  logic clk,
  input  logic reset,
  complex_dot_product_feeder_if.master bus
);
  localparam int P     = (NOE + NI - 1) / NI;
  localparam int PAD   = P * NI - NOE;
  localparam int PKG_W = element_width * NI;
  localparam int KW    = (P > 1) ? $clog2(P) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [KW-1:0]    K_LAST   = KW'(P - 1);
  localparam logic [TW-1:0]    T_LOAD   = TW'(TIMEOUT - 1);
  // element 0 sits in the MSBs, so padding slots are the low-order bits of the last package
  localparam logic [PKG_W-1:0] PAD_MASK = {PKG_W{1'b1}} << (PAD * element_width);

  typedef enum logic [2:0] {IDLE, CLR, FETCH, LOAD, DRIVE0, DRIVE1, WAIT_FIN, RESULT} state_t;

  state_t                   state;
  logic [KW-1:0]            k;
  logic [KW-1:0]            k_inc;
  logic [TW-1:0]            tmr;
  logic [ADDR_W-1:0]        a_addr_q;
  logic [ADDR_W-1:0]        b_addr_q;
  logic                     rd_q;
  logic                     dp_reset_q;
  logic                     read_now_q;
  logic [PKG_W-1:0]         first_row_q;
  logic [PKG_W-1:0]         second_row_q;
  logic [element_width-1:0] result_q;
  logic                     valid_q;
  logic                     error_q;
  logic                     busy_q;

  assign k_inc = k + KW'(1);

  function automatic logic [PKG_W-1:0] shape(input logic [PKG_W-1:0] pkg,
                                             input logic [KW-1:0]    idx);
    return (idx == K_LAST) ? (pkg & PAD_MASK) : pkg;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      k            <= '0;
      tmr          <= '0;
      a_addr_q     <= '0;
      b_addr_q     <= '0;
      rd_q         <= 1'b0;
      dp_reset_q   <= 1'b0;
      read_now_q   <= 1'b0;
      first_row_q  <= '0;
      second_row_q <= '0;
      result_q     <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rd_q       <= 1'b0;
      dp_reset_q <= 1'b0;
      read_now_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_addr_q   <= bus.a_base;
            b_addr_q   <= bus.b_base;
            k          <= '0;
            busy_q     <= 1'b1;
            dp_reset_q <= 1'b1;
            state      <= CLR;
          end
        end
        CLR: begin
          rd_q  <= 1'b1;
          state <= FETCH;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          first_row_q  <= shape(bus.mem_a_rdata, k);
          second_row_q <= shape(bus.mem_b_rdata, k);
          read_now_q   <= (k == '0);
          if (k != K_LAST) begin
            rd_q     <= 1'b1;
            a_addr_q <= a_addr_q + ADDR_W'(1);
            b_addr_q <= b_addr_q + ADDR_W'(1);
          end
          state <= DRIVE0;
        end
        DRIVE0: state <= DRIVE1;
        DRIVE1: begin
          if (k != K_LAST) begin
            first_row_q  <= shape(bus.mem_a_rdata, k_inc);
            second_row_q <= shape(bus.mem_b_rdata, k_inc);
            k            <= k_inc;
            if (k_inc != K_LAST) begin
              rd_q     <= 1'b1;
              a_addr_q <= a_addr_q + ADDR_W'(1);
              b_addr_q <= b_addr_q + ADDR_W'(1);
            end
            state <= DRIVE0;
          end else begin
            tmr   <= T_LOAD;
            state <= WAIT_FIN;
          end
        end
        WAIT_FIN: begin
          // a finish on the terminal-count cycle still wins over the timeout
          if (bus.dp_finish) begin
            result_q <= bus.dp_result;
            error_q  <= 1'b0;
            valid_q  <= 1'b1;
            state    <= RESULT;
          end else if (tmr == '0) begin
            result_q <= '0;
            error_q  <= 1'b1;
            valid_q  <= 1'b1;
            state    <= RESULT;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        RESULT: begin
          if (bus.result_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.mem_a_rd      = rd_q;
  assign bus.mem_b_rd      = rd_q;
  assign bus.mem_a_addr    = a_addr_q;
  assign bus.mem_b_addr    = b_addr_q;
  assign bus.dp_reset      = dp_reset_q;
  assign bus.dp_read_now   = read_now_q;
  assign bus.dp_first_row  = first_row_q;
  assign bus.dp_second_row = second_row_q;
  assign bus.result        = result_q;
  assign bus.result_valid  = valid_q;
  assign bus.result_error  = error_q;
endmodule

// File: tb/tb_complex_dot_product_feeder.sv
// Bench for complex_dot_product_feeder: one instance with a single package per row
// (NOE=8) and one with two packages (NOE=12), each fed by a one-cycle-latency row memory.
module tb_complex_dot_product_feeder;
  localparam int EW    = 64;
  localparam int NI    = 8;
  localparam int AW    = 10;
  localparam int PKG_W = EW * NI;
  localparam logic [PKG_W-1:0] ONES_PKG = {NI{64'h0000000100000001}};

  logic clk = 1'b0;
  logic reset;
  logic ones_mode = 1'b0;

  complex_dot_product_feeder_if #(.element_width(EW), .NI(NI), .ADDR_W(AW)) bus8 ();
  complex_dot_product_feeder_if #(.element_width(EW), .NI(NI), .ADDR_W(AW)) bus12 ();

  complex_dot_product_feeder #(.element_width(EW), .NI(NI), .NOE(8), .ADDR_W(AW), .TIMEOUT(255))
    dut8 (.clk(clk), .reset(reset), .bus(bus8));
  complex_dot_product_feeder #(.element_width(EW), .NI(NI), .NOE(12), .ADDR_W(AW), .TIMEOUT(255))
    dut12 (.clk(clk), .reset(reset), .bus(bus12));

  always #5 clk = ~clk;

  typedef struct {
    logic [EW-1:0] res;
    logic          err;
  } exp_t;

  typedef struct {
    logic          ones;
    logic [AW-1:0] a_base;
    logic [AW-1:0] b_base;
    int            fin_delay;    // WAIT_FIN cycle index carrying dp_finish, -1 = never
    logic [EW-1:0] dp_res;
    int            ready_delay;  // cycles result_ready is held low
    logic [EW-1:0] exp_res;
    logic          exp_err;
    int            exp_lat;      // cycles from WAIT_FIN entry to result_valid
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rd8 = 0;
  int   rn8 = 0;

  function automatic logic [EW-1:0] mem_elem(input logic sel, input logic [AW-1:0] addr, input int j);
    return {4'hC, 3'(j), sel, 14'h0, addr, 32'h1000_0001 + 32'(j)};
  endfunction

  function automatic logic [PKG_W-1:0] mem_pkg(input logic sel, input logic [AW-1:0] addr);
    logic [PKG_W-1:0] p;
    for (int j = 0; j < NI; j++) p[(NI-1-j)*EW +: EW] = mem_elem(sel, addr, j);
    return p;
  endfunction

  // expected row contents for package k of a row holding noe valid elements
  function automatic logic [PKG_W-1:0] exp_pkg(input logic sel, input logic [AW-1:0] addr,
                                               input int k, input int noe);
    logic [PKG_W-1:0] p;
    for (int j = 0; j < NI; j++)
      p[(NI-1-j)*EW +: EW] = (k * NI + j < noe) ? mem_elem(sel, addr, j) : '0;
    return p;
  endfunction

  always @(posedge clk) begin
    if (bus8.mem_a_rd)  bus8.mem_a_rdata  <= ones_mode ? ONES_PKG : mem_pkg(1'b0, bus8.mem_a_addr);
    if (bus8.mem_b_rd)  bus8.mem_b_rdata  <= ones_mode ? ONES_PKG : mem_pkg(1'b1, bus8.mem_b_addr);
    if (bus12.mem_a_rd) bus12.mem_a_rdata <= mem_pkg(1'b0, bus12.mem_a_addr);
    if (bus12.mem_b_rd) bus12.mem_b_rdata <= mem_pkg(1'b1, bus12.mem_b_addr);
  end

  always @(negedge clk) begin
    if (bus8.mem_a_rd)    rd8 <= rd8 + 1;
    if (bus8.dp_read_now) rn8 <= rn8 + 1;
  end

  task automatic chk(input string name, input logic [PKG_W-1:0] act, input logic [PKG_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [EW-1:0] res, input logic err);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s:scoreboard got result %0h with no expected entry queued", tag, res);
    end else begin
      e = sb.pop_front();
      chk({tag, ":result"}, res, e.res);
      chk({tag, ":result_error"}, err, e.err);
    end
  endtask

  task automatic idle8(input string tag);
    chk({tag, ":busy"}, bus8.busy, 0);
    chk({tag, ":mem_a_rd"}, bus8.mem_a_rd, 0);
    chk({tag, ":mem_b_rd"}, bus8.mem_b_rd, 0);
    chk({tag, ":dp_reset"}, bus8.dp_reset, 0);
    chk({tag, ":dp_read_now"}, bus8.dp_read_now, 0);
    chk({tag, ":result_valid"}, bus8.result_valid, 0);
    chk({tag, ":result_error"}, bus8.result_error, 0);
    chk({tag, ":result"}, bus8.result, 0);
    chk({tag, ":first_row"}, bus8.dp_first_row, 0);
    chk({tag, ":second_row"}, bus8.dp_second_row, 0);
  endtask

  // single-package job; called and returns on a falling edge
  task automatic run8(input vec_t v, input string tag);
    logic [PKG_W-1:0] ea, eb;
    int rd0, rn0, n;
    exp_t e;
    ea = v.ones ? ONES_PKG : exp_pkg(1'b0, v.a_base, 0, 8);
    eb = v.ones ? ONES_PKG : exp_pkg(1'b1, v.b_base, 0, 8);
    ones_mode = v.ones;
    rd0 = rd8;
    rn0 = rn8;
    e.res = v.exp_res;
    e.err = v.exp_err;
    sb.push_back(e);
    bus8.a_base = v.a_base;
    bus8.b_base = v.b_base;
    bus8.start  = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    chk({tag, ":c1_dp_reset"}, bus8.dp_reset, 1);
    chk({tag, ":c1_busy"}, bus8.busy, 1);
    @(negedge clk);
    chk({tag, ":c2_rd_a"}, bus8.mem_a_rd, 1);
    chk({tag, ":c2_rd_b"}, bus8.mem_b_rd, 1);
    chk({tag, ":c2_addr_a"}, bus8.mem_a_addr, v.a_base);
    chk({tag, ":c2_addr_b"}, bus8.mem_b_addr, v.b_base);
    @(negedge clk);
    chk({tag, ":c3_rd"}, bus8.mem_a_rd, 0);
    @(negedge clk);
    chk({tag, ":c4_read_now"}, bus8.dp_read_now, 1);
    chk({tag, ":c4_row_a"}, bus8.dp_first_row, ea);
    chk({tag, ":c4_row_b"}, bus8.dp_second_row, eb);
    @(negedge clk);
    chk({tag, ":c5_read_now"}, bus8.dp_read_now, 0);
    chk({tag, ":c5_row_a"}, bus8.dp_first_row, ea);
    @(negedge clk);
    n = 0;
    while (bus8.result_valid !== 1'b1 && n < 400) begin
      bus8.dp_finish = (n == v.fin_delay);
      bus8.dp_result = v.dp_res;
      @(negedge clk);
      n++;
    end
    bus8.dp_finish = 1'b0;
    chk({tag, ":wait_cycles"}, n, v.exp_lat);
    chk({tag, ":held_row_a"}, bus8.dp_first_row, ea);
    chk({tag, ":held_row_b"}, bus8.dp_second_row, eb);
    sb_check(tag, bus8.result, bus8.result_error);
    for (int i = 0; i < v.ready_delay; i++) begin
      chk({tag, ":hold_valid"}, bus8.result_valid, 1);
      chk({tag, ":hold_result"}, bus8.result, v.exp_res);
      chk({tag, ":hold_busy"}, bus8.busy, 1);
      bus8.start = i[0];
      @(negedge clk);
    end
    bus8.result_ready = 1'b1;
    bus8.start        = 1'b1;
    chk({tag, ":accept_valid"}, bus8.result_valid, 1);
    @(negedge clk);
    bus8.result_ready = 1'b0;
    bus8.start        = 1'b0;
    chk({tag, ":post_valid"}, bus8.result_valid, 0);
    chk({tag, ":post_busy"}, bus8.busy, 0);
    @(negedge clk);
    chk({tag, ":dropped_start_dp_reset"}, bus8.dp_reset, 0);
    @(negedge clk);
    chk({tag, ":dropped_start_busy"}, bus8.busy, 0);
    chk({tag, ":read_count"}, rd8 - rd0, 1);
    chk({tag, ":read_now_count"}, rn8 - rn0, 1);
  endtask

  // two-package job on the NOE=12 instance, checked cycle by cycle
  task automatic run12(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [EW-1:0] res,
                       input string tag);
    logic [AW-1:0] a1, b1;
    logic [PKG_W-1:0] a0p, b0p, a1p, b1p;
    exp_t e;
    a1  = a + 10'd1;
    b1  = b + 10'd1;
    a0p = exp_pkg(1'b0, a, 0, 12);
    b0p = exp_pkg(1'b1, b, 0, 12);
    a1p = exp_pkg(1'b0, a1, 1, 12);
    b1p = exp_pkg(1'b1, b1, 1, 12);
    e.res = res;
    e.err = 1'b0;
    sb.push_back(e);
    bus12.a_base = a;
    bus12.b_base = b;
    bus12.start  = 1'b1;
    @(negedge clk);
    bus12.start = 1'b0;
    chk({tag, ":c1_dp_reset"}, bus12.dp_reset, 1);
    @(negedge clk);
    chk({tag, ":c2_rd"}, bus12.mem_a_rd & bus12.mem_b_rd, 1);
    chk({tag, ":c2_addr_a"}, bus12.mem_a_addr, a);
    chk({tag, ":c2_addr_b"}, bus12.mem_b_addr, b);
    @(negedge clk);
    @(negedge clk);
    chk({tag, ":c4_read_now"}, bus12.dp_read_now, 1);
    chk({tag, ":c4_row_a"}, bus12.dp_first_row, a0p);
    chk({tag, ":c4_row_b"}, bus12.dp_second_row, b0p);
    chk({tag, ":c4_rd"}, bus12.mem_a_rd & bus12.mem_b_rd, 1);
    chk({tag, ":c4_addr_a"}, bus12.mem_a_addr, a1);
    chk({tag, ":c4_addr_b"}, bus12.mem_b_addr, b1);
    @(negedge clk);
    chk({tag, ":c5_row_a"}, bus12.dp_first_row, a0p);
    chk({tag, ":c5_rd"}, bus12.mem_a_rd, 0);
    chk({tag, ":c5_read_now"}, bus12.dp_read_now, 0);
    @(negedge clk);
    chk({tag, ":c6_row_a"}, bus12.dp_first_row, a1p);
    chk({tag, ":c6_row_b"}, bus12.dp_second_row, b1p);
    chk({tag, ":c6_pad_a"}, bus12.dp_first_row[255:0], 0);
    chk({tag, ":c6_pad_b"}, bus12.dp_second_row[255:0], 0);
    chk({tag, ":c6_read_now"}, bus12.dp_read_now, 0);
    @(negedge clk);
    chk({tag, ":c7_row_a"}, bus12.dp_first_row, a1p);
    chk({tag, ":c7_rd"}, bus12.mem_a_rd, 0);
    @(negedge clk);
    chk({tag, ":c8_row_b"}, bus12.dp_second_row, b1p);
    chk({tag, ":c8_valid"}, bus12.result_valid, 0);
    bus12.dp_finish = 1'b1;
    bus12.dp_result = res;
    @(negedge clk);
    bus12.dp_finish = 1'b0;
    chk({tag, ":c9_valid"}, bus12.result_valid, 1);
    sb_check(tag, bus12.result, bus12.result_error);
    bus12.result_ready = 1'b1;
    @(negedge clk);
    bus12.result_ready = 1'b0;
    chk({tag, ":c10_valid"}, bus12.result_valid, 0);
    chk({tag, ":c10_busy"}, bus12.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd0, rn0;
    vecs[0] = '{1'b1, 10'h000, 10'h000, 3,  64'h0000001000000000, 0,
                64'h0000001000000000, 1'b0, 4};
    vecs[1] = '{1'b0, 10'h155, 10'h2AA, 0,  64'hDEADBEEF12345678, 10,
                64'hDEADBEEF12345678, 1'b0, 1};
    vecs[2] = '{1'b0, 10'h3FF, 10'h001, -1, 64'hFFFFFFFFFFFFFFFF, 2,
                64'h0000000000000000, 1'b1, 255};
    vecs[3] = '{1'b0, 10'h007, 10'h009, 254, 64'h0123456789ABCDEF, 1,
                64'h0123456789ABCDEF, 1'b0, 255};
    vecs[4] = '{1'b0, 10'h200, 10'h1FF, 5,  64'h8000000000000001, 0,
                64'h8000000000000001, 1'b0, 6};

    reset = 1'b1;
    bus8.start = 1'b1;  bus8.a_base = '0;  bus8.b_base = '0;
    bus8.dp_finish = 1'b0;  bus8.dp_result = '0;  bus8.result_ready = 1'b0;
    bus8.mem_a_rdata = '0;  bus8.mem_b_rdata = '0;
    bus12.start = 1'b1; bus12.a_base = '0; bus12.b_base = '0;
    bus12.dp_finish = 1'b0; bus12.dp_result = '0; bus12.result_ready = 1'b0;
    bus12.mem_a_rdata = '0; bus12.mem_b_rdata = '0;
    repeat (3) @(negedge clk);
    idle8("reset");
    chk("reset:busy12", bus12.busy, 0);
    chk("reset:valid12", bus12.result_valid, 0);
    chk("reset:row12", bus12.dp_first_row, 0);
    reset = 1'b0;
    bus8.start  = 1'b0;
    bus12.start = 1'b0;
    @(negedge clk);
    chk("after_reset:busy", bus8.busy, 0);
    chk("after_reset:dp_reset", bus8.dp_reset, 0);

    for (int i = 0; i < 5; i++) run8(vecs[i], $sformatf("v%0d", i));

    // reset while package 0 is in DRIVE1
    ones_mode = 1'b0;
    rd0 = rd8;
    rn0 = rn8;
    bus8.a_base = 10'h0AB;
    bus8.b_base = 10'h0CD;
    bus8.start  = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort:pre_busy", bus8.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    idle8("abort");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort:read_count", rd8 - rd0, 1);
    chk("abort:read_now_count", rn8 - rn0, 1);
    chk("abort:late_valid", bus8.result_valid, 0);
    chk("abort:late_busy", bus8.busy, 0);
    run8(vecs[1], "post_abort");

    run12(10'h3FF, 10'h005, 64'hCAFEF00D0BADBEEF, "p2_wrap");
    run12(10'h010, 10'h020, 64'h00000003FFFFFFFD, "p2");

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/complex_dot_product_feeder.md
COMPLEX_DOT_PRODUCT_FEEDER -- requirements
Module: complex_dot_product_feeder

Interface
REQ-001 SHALL have parameters:
- element_width, 64, complex element width (real = upper 32 bits, imag = lower 32 bits).
- NI, 8, elements per package.
- NOE, 8, valid elements per row.
- ADDR_W, 10, package address width.
- TIMEOUT, 255, maximum cycles to wait for dp_finish.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  job request pulse.
- a_base, b_base  in  ADDR_W  first/second row package base addresses.
- busy  out  1  job in progress.
- mem_a_rd, mem_b_rd  out  1  row memory read strobes.
- mem_a_addr, mem_b_addr  out  ADDR_W  package addresses.
- mem_a_rdata, mem_b_rdata  in  element_width*NI  package data; valid exactly 1 cycle after the strobe.
- dp_reset  out  1  reset to the dot-product unit.
- dp_read_now  out  1  package-stream start pulse.
- dp_first_row, dp_second_row  out  element_width*NI  package to the unit; element 0 in the MSBs.
- dp_finish  in  1  unit done.
- dp_result  in  element_width  unit result.
- result  out  element_width  captured dot product.
- result_valid  out  1  result available.
- result_error  out  1  timeout occurred.
- result_ready  in  1  consumer accepts result.

Function
REQ-003 SHALL compute P = ceil(NOE/NI) packages; PAD = P*NI-NOE.
REQ-004 SHALL use states IDLE, CLR, FETCH, LOAD, DRIVE0, DRIVE1, WAIT_FIN, RESULT.
REQ-005 IDLE: busy=0; start=1 -> latch a_base/b_base, clear package index k, go to CLR.
REQ-006 CLR: dp_reset=1 for exactly 1 cycle, then FETCH.
REQ-007 FETCH: mem_a_rd=mem_b_rd=1, addr = base+k, 1 cycle, then LOAD.
REQ-008 LOAD: register mem_*_rdata into dp_*_row at the clock edge, then DRIVE0.
REQ-009 Packages SHALL reach dp_*_row registers only, never combinationally.
REQ-010 Package P-1: the last PAD elements (lowest-order element slots) SHALL be forced to zero in both rows.
REQ-011 DRIVE0: dp_read_now=1 only when k=0; if k<P-1, issue reads for k+1 this cycle.
REQ-012 DRIVE1: if k<P-1, load package k+1 at the edge, increment k, go to DRIVE0; else go to WAIT_FIN.
REQ-013 Each package SHALL stay stable exactly 2 cycles (DRIVE0, DRIVE1).
REQ-014 The last package SHALL stay held through WAIT_FIN.
REQ-015 dp_read_now SHALL pulse exactly once per job.
REQ-016 WAIT_FIN: count cycles. dp_finish=1 -> result<=dp_result, result_error<=0, go to RESULT.
REQ-017 WAIT_FIN: count reaches TIMEOUT with no dp_finish -> result<=0, result_error<=1, go to RESULT.
REQ-018 RESULT: result_valid=1; result/result_error held until result_ready=1, then IDLE with result_valid<=0 next cycle.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 start while busy SHALL be ignored and not queued.
REQ-021 start and result_ready coincident in RESULT: accept the result only; the start is dropped.
REQ-022 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-023 mem_*_rd, dp_reset and dp_read_now SHALL be single-cycle strobes; addr values are don't-care when the strobe is low.
REQ-024 Latency, P=1: start at cycle 0 -> dp_reset cycle 1, reads cycle 2, dp_read_now cycle 4.

Reset
REQ-025 reset SHALL dominate start and all other inputs.
REQ-026 On reset: state=IDLE; outputs busy, mem_a_rd, mem_b_rd, dp_reset, dp_read_now, result_valid, result_error = 0.
REQ-027 On reset: dp_first_row, dp_second_row, result, k, timeout counter = 0.
REQ-028 reset mid-job SHALL abort with no result_valid and no further strobes.

Verification
REQ-029 NOE=8, NI=8, start, rows all 0x0000000100000001 -> one read, one dp_read_now at cycle 4, rows held until finish; dp_finish with dp_result=0x0000001000000000 -> result equals it, result_valid=1.
REQ-030 NOE=12, NI=8 -> P=2, addresses base and base+1; second package has its 4 low element slots zero; packages change exactly 2 cycles apart.
REQ-031 dp_finish never asserted, TIMEOUT=255 -> result_valid with result_error=1, result=0 exactly 255 WAIT_FIN cycles after entry.
REQ-032 result_ready held low 10 cycles -> result_valid and result stable; extra start pulses ignored; busy=1 throughout.
REQ-033 reset asserted in DRIVE1 of package 0 -> next cycle all outputs 0, IDLE; a new start runs a clean job.
REQ-034 a_base=2^ADDR_W-1, P=2 -> second read address = 0.
